trace_packet_fifo: RTL and testbench



---
 rtl/trace_packet_fifo.sv | 179 +++++++++++++++++
 tb/tb_trace_packet_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_packet_fifo.sv
// trace_packet_fifo: elastic buffer from the tracer (no back-pressure) to the USB writer.
// Ports: mclk/reset (async, active-high), flush; in_data/in_strobe from the tracer;
// out_data/out_valid/out_ready handshake to the USB side; level and drop_pending status;
// peak_level/clear_peak high-water mark, present only when TRACE_FIFO_PEAK_EN is defined.
// level counts words still in RAM and excludes the word held in the output register.
// Overflow drops and counts words, then inserts {MARKER_TAG, drop_count} once 2 words are free.
module trace_packet_fifo #(
    parameter int          DEPTH_LOG2 = 9,
    parameter logic [15:0] MARKER_TAG = 16'hFFFF
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic                flush,
    input  logic [31:0]         in_data,
    input  logic                in_strobe,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DEPTH_LOG2:0] level,
    output logic                drop_pending,
    output logic [DEPTH_LOG2:0] peak_level,
    input  logic                clear_peak
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    localparam cnt_t FULL     = cnt_t'(DEPTH);
    localparam cnt_t MARK_MAX = cnt_t'(DEPTH - 2);

    logic [31:0] mem_q [DEPTH];

    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    cnt_t        avail;
    logic        drop_pend_q, drop_pend_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        pf_valid_q, pf_valid_d;
    logic [31:0] pf_data_q;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;

    logic        consume;
    logic        pop;
    logic        accept;
    logic        drop;
    logic        mark;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_word;

    always_comb begin
        consume = out_valid_q & out_ready;
        // pop moves the prefetched head into the output register and frees its slot
        pop     = pf_valid_q & (~out_valid_q | consume);
        accept  = in_strobe & ~drop_pend_q & (count_q != FULL);
        drop    = in_strobe & ~accept;
        mark    = ~in_strobe & drop_pend_q & (count_q <= MARK_MAX);
        wr_en   = ~flush & (accept | mark);
        wr_word = mark ? {MARKER_TAG, drop_cnt_q} : in_data;
        // words already readable after this pop; a word written this edge is not
        avail   = count_q - cnt_t'(pop);
        rd_en   = ~flush & (avail != '0);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        drop_pend_d = drop_pend_q;
        drop_cnt_d  = drop_cnt_q;
        pf_valid_d  = pf_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            drop_pend_d = 1'b0;
            drop_cnt_d  = '0;
            pf_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
            count_d    = count_q + cnt_t'(wr_en) - cnt_t'(pop);
            pf_valid_d = rd_en;
            if (pop) begin
                out_valid_d = 1'b1;
                out_data_d  = pf_data_q;
            end else if (consume) begin
                out_valid_d = 1'b0;
            end
            if (drop) begin
                drop_pend_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end else if (mark) begin
                drop_pend_d = 1'b0;
                drop_cnt_d  = '0;
            end
        end
    end

    // Storage RAM; the read port refreshes the prefetch register every cycle
    // from the slot that will be the head after this edge.
    always_ff @(posedge mclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
        if (rd_en) begin
            pf_data_q <= mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_pend_q <= 1'b0;
            drop_cnt_q  <= '0;
            pf_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_pend_q <= drop_pend_d;
            drop_cnt_q  <= drop_cnt_d;
            pf_valid_q  <= pf_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign level        = count_q;
    assign drop_pending = drop_pend_q;

`ifdef TRACE_FIFO_PEAK_EN
    cnt_t peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (clear_peak) begin
            peak_d = count_q;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`else
    logic unused_clear_peak;
    assign unused_clear_peak = clear_peak;
    assign peak_level        = '0;
`endif

endmodule

// File: tb/tb_trace_packet_fifo.sv
// Self-checking bench for trace_packet_fifo (DEPTH_LOG2=4) against a queue-based model.
// Compile with +define+TRACE_FIFO_PEAK_EN to exercise the high-water mark.
module tb_trace_packet_fifo;

    localparam int DL = 4;
    localparam int D  = 16;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_strobe = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_peak = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [DL:0] level;
    logic        drop_pending;
    logic [DL:0] peak_level;

    always #5 mclk = ~mclk;

    trace_packet_fifo #(
        .DEPTH_LOG2(DL),
        .MARKER_TAG(16'hFFFF)
    ) dut (
        .mclk        (mclk),
        .reset       (reset),
        .flush       (flush),
        .in_data     (in_data),
        .in_strobe   (in_strobe),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .drop_pending(drop_pending),
        .peak_level  (peak_level),
        .clear_peak  (clear_peak)
    );

    typedef struct {
        logic [31:0] d;
        int          t;
    } ent_t;

    ent_t        mq[$];
    bit          m_ov;
    logic [31:0] m_od;
    bit          m_dp;
    int          m_dc;
    int          m_peak;
    int          edge_n = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov   = 0;
        m_od   = '0;
        m_dp   = 0;
        m_dc   = 0;
        m_peak = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held at the edge.
    task automatic model_edge();
        int  pre;
        bit  cons;
        ent_t e;
        edge_n++;
        pre = mq.size();
        if (flush) begin
            model_reset();
            return;
        end
        cons = m_ov && out_ready;
        // a word written at edge k may appear in the output register at edge k+2
        if ((!m_ov || cons) && mq.size() > 0 && mq[0].t <= edge_n - 2) begin
            e    = mq.pop_front();
            m_od = e.d;
            m_ov = 1;
        end else if (cons) begin
            m_ov = 0;
        end
        if (in_strobe && !m_dp && pre < D) begin
            mq.push_back('{in_data, edge_n});
        end else if (in_strobe) begin
            m_dp = 1;
            if (m_dc < 65535) m_dc++;
        end else if (m_dp && pre <= D - 2) begin
            mq.push_back('{{16'hFFFF, m_dc[15:0]}, edge_n});
            m_dp = 0;
            m_dc = 0;
        end
        if (clear_peak) m_peak = pre;
        else if (mq.size() > m_peak) m_peak = mq.size();
    endtask

    task automatic compare();
        int exp_peak;
`ifdef TRACE_FIFO_PEAK_EN
        exp_peak = m_peak;
`else
        exp_peak = 0;
`endif
        check("level", 32'(level), 32'(mq.size()));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("drop_pending", 32'(drop_pending), 32'(m_dp));
        check("peak_level", 32'(peak_level), 32'(exp_peak));
        if (m_ov) check("out_data", out_data, m_od);
    endtask

    task automatic cyc();
        @(posedge mclk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input bit stb, input logic [31:0] d, input bit rdy);
        in_strobe = stb;
        in_data   = d;
        out_ready = rdy;
        cyc();
        in_strobe = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, rdy);
    endtask

    initial begin
        model_reset();
        #2;
        compare();
        check("rst_out_data", out_data, 32'h0);
        #1 reset = 1'b0;

        // single word, latency and return to empty
        drive(1'b1, 32'h12345678, 1'b1);
        idle(5, 1'b1);

        // fill with the consumer stalled, overflow, then drain
        for (int i = 0; i < 17; i++) drive(1'b1, 32'h100 + i, 1'b0);
        check("t2_full", 32'(level), 32'(D));
        drive(1'b1, 32'hDEAD0000, 1'b0);
        check("t2_drop", 32'(drop_pending), 32'h1);
        idle(30, 1'b1);

        // five drops, brief drain, marker then the next packet
        for (int i = 0; i < 17; i++) drive(1'b1, 32'h200 + i, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'hBAD0 + i, 1'b0);
        idle(3, 1'b1);
        idle(1, 1'b0);
        drive(1'b1, 32'hA5A5A5A5, 1'b0);
        idle(30, 1'b1);

        // full-rate streaming
        for (int i = 0; i < 100; i++) drive(1'b1, $urandom, 1'b1);
        idle(6, 1'b1);

        // flush with a pending drop and a coincident strobe
        for (int i = 0; i < 18; i++) drive(1'b1, 32'h300 + i, 1'b0);
        for (int i = 0; i < 40 && level > 8; i++) drive(1'b1, 32'hBEEF, 1'b1);
        check("t5_half", 32'(level), 32'd8);
        flush = 1'b1;
        drive(1'b1, 32'hF1F1F1F1, 1'b0);
        flush = 1'b0;
        check("t5_flush_lvl", 32'(level), 32'h0);
        check("t5_flush_dp", 32'(drop_pending), 32'h0);
        idle(3, 1'b0);
        drive(1'b1, 32'h00C0FFEE, 1'b1);
        idle(6, 1'b1);

        // high-water mark
        flush = 1'b1;
        idle(1, 1'b0);
        flush = 1'b0;
        for (int i = 0; i < 12; i++) drive(1'b1, 32'h400 + i, 1'b0);
        idle(8, 1'b1);
        clear_peak = 1'b1;
        idle(1, 1'b0);
        clear_peak = 1'b0;
        idle(2, 1'b0);
        idle(8, 1'b1);

        // asynchronous reset in the middle of a burst with a drop pending
        for (int i = 0; i < 19; i++) drive(1'b1, 32'h500 + i, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare();
        check("mid_rst_data", out_data, 32'h0);
        #2 reset = 1'b0;
        idle(2, 1'b1);

        // randomized traffic
        for (int blk = 0; blk < 8; blk++) begin
            int ps = $urandom_range(10, 95);
            int pr = $urandom_range(5, 95);
            for (int i = 0; i < 100; i++) begin
                flush      = ($urandom_range(0, 199) == 0);
                clear_peak = ($urandom_range(0, 49) == 0);
                drive(($urandom_range(0, 99) < ps), $urandom,
                      ($urandom_range(0, 99) < pr));
                flush      = 1'b0;
                clear_peak = 1'b0;
            end
        end
        idle(40, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
